// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_ctrl: merges ALU results and handshaked mem results onto the  |
// | regfile write port; optional WB_BYPASS_EN lets idle mem results skip the |
// | FIFO. Keeps a per-register busy scoreboard for outstanding loads.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [AW-1:0]       alu_rd_addr,
    input  logic [DW-1:0]       alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [AW-1:0]       mem_rd_addr,
    input  logic [DW-1:0]       mem_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd_addr,
    output logic [(2**AW)-1:0]  busy_vec,
    output logic [AW-1:0]       rd_addr,
    output logic                rd_wren,
    output logic [DW-1:0]       rd_data
);
    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_nr = 2 ** AW;
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    logic [AW-1:0]   r_fifo_addr_q [DEPTH];
    logic [AW-1:0]   r_fifo_addr_d [DEPTH];
    logic [DW-1:0]   r_fifo_data_q [DEPTH];
    logic [DW-1:0]   r_fifo_data_d [DEPTH];
    logic [c_pw-1:0] r_wptr_q, r_wptr_d;
    logic [c_pw-1:0] r_rptr_q, r_rptr_d;
    logic [c_cw-1:0] r_cnt_q, r_cnt_d;
    logic [c_nr-1:0] r_busy_q, r_busy_d;
    logic            r_wren_q, r_wren_d;
    logic [AW-1:0]   r_addr_q, r_addr_d;
    logic [DW-1:0]   r_data_q, r_data_d;

    logic            w_alu_sel;
    logic            w_empty;
    logic            w_xfer;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;
    logic [AW-1:0]   w_head_addr;
    logic [DW-1:0]   w_head_data;

    assign mem_ready   = (r_cnt_q != c_full);
    assign w_empty     = (r_cnt_q == '0);
    assign w_alu_sel   = alu_valid && (alu_rd_addr != '0);
    assign w_xfer      = mem_valid && mem_ready;
    assign w_pop       = !w_alu_sel && !w_empty;
`ifdef WB_BYPASS_EN
    assign w_bypass    = !w_alu_sel && w_empty && w_xfer;
`else
    assign w_bypass    = 1'b0;
`endif
    assign w_push      = w_xfer && !w_bypass;
    assign w_head_addr = r_fifo_addr_q[r_rptr_q];
    assign w_head_data = r_fifo_data_q[r_rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        r_wptr_d      = r_wptr_q + c_pw'(w_push);
        r_rptr_d      = r_rptr_q + c_pw'(w_pop);
        r_cnt_d       = r_cnt_q + c_cw'(w_push) - c_cw'(w_pop);
        r_fifo_addr_d = r_fifo_addr_q;
        r_fifo_data_d = r_fifo_data_q;
        if (w_push) begin
            r_fifo_addr_d[r_wptr_q] = mem_rd_addr;
            r_fifo_data_d[r_wptr_q] = mem_data;
        end
    end

    always_comb begin
        r_wren_d = 1'b0;
        r_addr_d = '0;
        r_data_d = '0;
        r_busy_d = r_busy_q;
        if (w_alu_sel) begin
            r_wren_d = 1'b1;
            r_addr_d = alu_rd_addr;
            r_data_d = alu_data;
        end else if (w_pop) begin
            // A popped x0 result retires silently.
            r_wren_d = (w_head_addr != '0);
            r_addr_d = w_head_addr;
            r_data_d = (w_head_addr != '0) ? w_head_data : '0;
            r_busy_d[w_head_addr] = 1'b0;
        end else if (w_bypass) begin
            r_wren_d = (mem_rd_addr != '0);
            r_addr_d = mem_rd_addr;
            r_data_d = (mem_rd_addr != '0) ? mem_data : '0;
            r_busy_d[mem_rd_addr] = 1'b0;
        end
        if (iss_valid && (iss_rd_addr != '0)) begin
            r_busy_d[iss_rd_addr] = 1'b1;
        end
        r_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
            r_busy_q <= '0;
            r_wren_q <= 1'b0;
            r_addr_q <= '0;
            r_data_q <= '0;
        end else begin
            r_wptr_q <= r_wptr_d;
            r_rptr_q <= r_rptr_d;
            r_cnt_q  <= r_cnt_d;
            r_busy_q <= r_busy_d;
            r_wren_q <= r_wren_d;
            r_addr_q <= r_addr_d;
            r_data_q <= r_data_d;
        end
    end

    always_ff @(posedge clk) begin
        r_fifo_addr_q <= r_fifo_addr_d;
        r_fifo_data_q <= r_fifo_data_d;
    end

    assign rd_wren  = r_wren_q;
    assign rd_addr  = r_addr_q;
    assign rd_data  = r_data_q;
    assign busy_vec = r_busy_q;

endmodule
`default_nettype wire
